// File: rtl/arb_merge_rr_n.sv
// N-input round-robin arbitrated merge with registered, source-tagged output.
// Define ARB_MERGE_BURST_EN to let one input hold the grant for up to BURST words.
module arb_merge_rr_n #(
  parameter int N = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4,
  localparam int IDXW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [IDXW-1:0]      out_src,
  input  logic                 out_ready
);

  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

  logic [IDXW-1:0]  ptr;
  logic [IDXW-1:0]  ptr_nxt;
  logic [IDXW-1:0]  ptr_inc;
  logic [IDXW-1:0]  gnt;
  logic             found;
  logic             can_load;
  logic             in_fire;
  logic             out_fire;
  logic [WIDTH-1:0] gnt_data;

  // Scan downwards so the index nearest ptr is the last (winning) write.
  always_comb begin
    int j;
    j = 0;
    found = 1'b0;
    gnt = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (in_valid[j]) begin
        found = 1'b1;
        gnt = IDXW'(j);
      end
    end
  end

  assign can_load = !out_valid || out_ready;
  assign in_fire  = found && can_load;
  assign out_fire = out_valid && out_ready;
  assign ptr_inc  = (gnt == LAST) ? '0 : gnt + 1'b1;

  always_comb begin
    in_ready = '0;
    if (in_fire) in_ready[gnt] = 1'b1;
  end

  always_comb begin
    gnt_data = in_data[int'(gnt)*WIDTH +: WIDTH];
  end

`ifdef ARB_MERGE_BURST_EN
  localparam int CW = (BURST < 2) ? 1 : $clog2(BURST + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // While bursting, ptr parks on the holder so the scan re-picks it first.
  always_comb begin
    cnt_nxt = cnt;
    ptr_nxt = ptr;
    if (in_fire) begin
      if (gnt == ptr && cnt != '0) cnt_nxt = cnt + 1'b1;
      else cnt_nxt = CW'(1);
      if (cnt_nxt == CW'(BURST)) begin
        cnt_nxt = '0;
        ptr_nxt = ptr_inc;
      end else begin
        ptr_nxt = gnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else cnt <= cnt_nxt;
  end
`else
  logic unused_burst;
  assign unused_burst = ^BURST;
  assign ptr_nxt = in_fire ? ptr_inc : ptr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else begin
      ptr <= ptr_nxt;
      if (in_fire) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_src   <= gnt;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_merge_rr_n.sv
// Bench for arb_merge_rr_n: directed vector table, hand sequences,
// and a randomized run against a grant-level reference model.
module tb_arb_merge_rr_n;
  localparam int N = 4;
  localparam int W = 8;
  localparam int BURST = 4;
  localparam int IDXW = 2;
`ifdef ARB_MERGE_BURST_EN
  localparam int B = BURST;
`else
  localparam int B = 1;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    in_valid = '0;
  logic [N*W-1:0]  in_data = '0;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [IDXW-1:0] out_src;
  logic            out_ready = 1'b0;

  arb_merge_rr_n #(.N(N), .WIDTH(W), .BURST(BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = '0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [N-1:0]    iv;
    logic [N*W-1:0]  d;
    logic            ordy;
    logic [N-1:0]    ir;
    logic            ov;
    logic [W-1:0]    od;
    logic [IDXW-1:0] os;
  } vec_t;

  vec_t tbl[10];

  // Reference model state: last grant holder and its run length.
  int              last_g;
  int              run;
  logic            m_ov;
  logic [W-1:0]    m_od;
  logic [IDXW-1:0] m_os;
  logic [W-1:0]    sq[N][$];
  logic [W-1:0]    pend[N];
  int              waitc[N];

  function automatic int model_grant(input logic [N-1:0] v);
    int start;
    if (last_g >= 0 && run > 0 && run < B && v[last_g]) return last_g;
    start = (last_g < 0) ? 0 : (last_g + 1) % N;
    for (int k = 0; k < N; k++)
      if (v[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    last_g = -1;
    run = 0;
    m_ov = 1'b0;
    m_od = '0;
    m_os = '0;
    for (int i = 0; i < N; i++) begin
      sq[i].delete();
      waitc[i] = 0;
      pend[i] = W'($urandom);
    end
  endtask

  task automatic rnd_step(input logic [N-1:0] iv, input logic ordy,
                          output int fired);
    int g;
    logic fire;
    logic [N-1:0] exp_ir;
    logic [W-1:0] w;
    in_valid = iv;
    out_ready = ordy;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = pend[i];
    #2;
    g = model_grant(iv);
    fire = (g >= 0) && (!m_ov || ordy);
    exp_ir = fire ? (N'(1) << g) : '0;
    chk("rnd_in_ready", 32'(in_ready), 32'(exp_ir));
    chk("rnd_out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      chk("rnd_out_data", 32'(out_data), 32'(m_od));
      chk("rnd_out_src", 32'(out_src), 32'(m_os));
    end
    if (m_ov && ordy) begin
      if (sq[m_os].size() == 0) begin
        chk("sb_underflow", 32'(1), 32'(0));
      end else begin
        w = sq[m_os].pop_front();
        chk("sb_order", 32'(out_data), 32'(w));
      end
    end
    fired = -1;
    if (fire) begin
      fired = g;
      for (int i = 0; i < N; i++) begin
        if (i != g && iv[i]) begin
          waitc[i]++;
          chk("wait_bound", 32'(waitc[i] <= (N - 1) * B), 32'(1));
        end
      end
      waitc[g] = 0;
      sq[g].push_back(pend[g]);
      m_od = pend[g];
      m_os = IDXW'(g);
      m_ov = 1'b1;
      run = (g == last_g && run < B) ? run + 1 : 1;
      last_g = g;
      pend[g] = W'($urandom);
    end else if (m_ov && ordy) begin
      m_ov = 1'b0;
    end
    for (int i = 0; i < N; i++) if (!iv[i]) waitc[i] = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] cur_iv;
    logic [N-1:0] exp_ir;
    int fired;
    int es;

    tbl[0] = '{iv:4'b0000, d:32'h0, ordy:1'b1,
               ir:4'b0000, ov:1'b0, od:8'h00, os:2'd0};
    tbl[1] = '{iv:4'b0100, d:32'h003C_0000, ordy:1'b1,
               ir:4'b0100, ov:1'b1, od:8'h3C, os:2'd2};
    tbl[2] = '{iv:4'b1000, d:32'hA500_0000, ordy:1'b1,
               ir:4'b1000, ov:1'b1, od:8'hA5, os:2'd3};
    tbl[3] = '{iv:4'b1001, d:32'h7700_0055, ordy:1'b1,
               ir:4'b0001, ov:1'b1, od:8'h55, os:2'd0};
    tbl[4] = '{iv:4'b1001, d:32'h7700_0055, ordy:1'b1,
               ir:4'b1000, ov:1'b1, od:8'h77, os:2'd3};
    tbl[5] = '{iv:4'b1111, d:32'h1312_1110, ordy:1'b0,
               ir:4'b0000, ov:1'b1, od:8'h77, os:2'd3};
    tbl[6] = '{iv:4'b1111, d:32'h1312_1110, ordy:1'b0,
               ir:4'b0000, ov:1'b1, od:8'h77, os:2'd3};
    tbl[7] = '{iv:4'b1111, d:32'h1312_1110, ordy:1'b1,
               ir:4'b0001, ov:1'b1, od:8'h10, os:2'd0};
    tbl[8] = '{iv:4'b1111, d:32'h1312_1110, ordy:1'b1,
               ir:4'b0010, ov:1'b1, od:8'h11, os:2'd1};
    tbl[9] = '{iv:4'b0000, d:32'h1312_1110, ordy:1'b1,
               ir:4'b0000, ov:1'b0, od:8'h11, os:2'd1};

    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_out_src", 32'(out_src), 32'(0));

    for (int r = 0; r < 10; r++) begin
      in_valid = tbl[r].iv;
      in_data = tbl[r].d;
      out_ready = tbl[r].ordy;
      #2;
      chk($sformatf("tbl%0d_in_ready", r), 32'(in_ready), 32'(tbl[r].ir));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_out_valid", r), 32'(out_valid), 32'(tbl[r].ov));
      if (tbl[r].ov) begin
        chk($sformatf("tbl%0d_out_data", r), 32'(out_data), 32'(tbl[r].od));
        chk($sformatf("tbl%0d_out_src", r), 32'(out_src), 32'(tbl[r].os));
      end
    end

    // Continuous demand from all inputs: rotation, one word per cycle.
    do_reset();
    in_valid = 4'b1111;
    in_data = 32'h1312_1110;
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      es = (k / B) % N;
      #2;
      chk("rot_in_ready", 32'(in_ready), 32'(1 << es));
      @(posedge clk);
      #1;
      chk("rot_out_valid", 32'(out_valid), 32'(1));
      chk("rot_out_src", 32'(out_src), 32'(es));
      chk("rot_out_data", 32'(out_data), 32'(8'h10 + es));
    end

    // Asynchronous reset while a word is held.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'(0));
    chk("async_rst_data", 32'(out_data), 32'(0));
    chk("async_rst_src", 32'(out_src), 32'(0));
    in_valid = 4'b0110;
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'(4'b0010));
    @(posedge clk);
    #1;
    chk("post_rst_src", 32'(out_src), 32'(1));
    chk("post_rst_data", 32'(out_data), 32'(8'h11));

    // Backpressure holds the word and blocks every input.
    do_reset();
    in_valid = 4'b1111;
    in_data = 32'h1312_1110;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_first_src", 32'(out_src), 32'(0));
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("bp_in_ready", 32'(in_ready), 32'(0));
      @(posedge clk);
      #1;
      chk("bp_hold_valid", 32'(out_valid), 32'(1));
      chk("bp_hold_data", 32'(out_data), 32'(8'h10));
      chk("bp_hold_src", 32'(out_src), 32'(0));
    end
    out_ready = 1'b1;
    es = (B > 1) ? 0 : 1;
    #2;
    chk("bp_release_ready", 32'(in_ready), 32'(1 << es));
    @(posedge clk);
    #1;
    chk("bp_release_src", 32'(out_src), 32'(es));

    // Randomized traffic against the reference model and scoreboard.
    do_reset();
    model_reset();
    cur_iv = '0;
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!cur_iv[i]) cur_iv[i] = 1'($urandom_range(0, 1));
        else if ($urandom_range(0, 15) == 0) cur_iv[i] = 1'b0;
      end
      rnd_step(cur_iv, ($urandom_range(0, 3) != 0), fired);
      if (fired >= 0) cur_iv[fired] = 1'($urandom_range(0, 1));
    end
    for (int c = 0; c < 3; c++) rnd_step('0, 1'b1, fired);
    for (int i = 0; i < N; i++)
      chk($sformatf("sb_left%0d", i), 32'(sq[i].size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
